mole_game_ctrl: RTL and testbench
=================================

// Module: mole_game_ctrl
// PURPOSE
//  Game controller for whack-a-mole; sits directly upstream of vga_display.
//  Picks a pseudo-random mole slot and times how long the mole stays up.
//  Judges debounced button hits, keeps a 2-digit BCD score, counts misses
//  and ends the game. Emits single-cycle guess_correct / guess_wrong /
//  game_over pulses plus mole_position and the score digits for rendering.
// PARAMETERS
//  MOLE_TICKS   100_000_000  initial mole-up time in clk cycles (1 s @ 100 MHz)
//  MIN_TICKS     25_000_000  floor for mole-up time after speed-ups
//  SPEEDUP_STEP   5_000_000  reduction of mole-up time per correct hit
//  MAX_MISSES             3  misses that end the game (1..7)
//  LFSR_SEED        16'hACE1 nonzero LFSR reset seed
// PORTS
//  clk            in   1   system clock (same clk as vga_display game logic)
//  rst            in   1   asynchronous, active-low reset
//  start          in   1   1-cycle pulse, debounced; starts/restarts a game
//  hit_valid      in   1   1-cycle pulse, debounced button press
//  hit_pos        in   3   slot pressed with hit_valid: 0 top,1 left,2 center,3 right,4 bot
//  mole_position  out  3   current mole slot, 0..4
//  guess_correct  out  1   1-cycle pulse: mole hit
//  guess_wrong    out  1   1-cycle pulse: wrong slot or mole timed out
//  game_over      out  1   1-cycle pulse on entry to OVER
//  digit_1        out  4   score tens, BCD
//  digit_2        out  4   score ones, BCD
//  playing        out  1   high in SPAWN/UP
// BEHAVIOUR
//  All outputs registered. Reset (rst=0): state IDLE, mole_position=2,
//   pulses 0, digits 0, playing 0, misses 0, timer 0, reload=MOLE_TICKS, lfsr=LFSR_SEED.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle in all states.
//  FSM IDLE -> SPAWN on start. OVER -> SPAWN on start (clears score, misses,
//   reload=MOLE_TICKS). start ignored in SPAWN/UP.
//  SPAWN (1 cycle): cand = lfsr[2:0], cand>=5 -> cand-5; cand==mole_position
//   -> (cand+1) mod 5 (never repeat a slot). Load mole_position=cand,
//   timer=reload-1. -> UP.
//  UP: timer decrements each cycle. Priority per cycle:
//   1 hit_valid & hit_pos==mole_position: guess_correct next cycle; score+1
//     BCD (ones 9->0 carries tens; 99 saturates); reload=max(reload-SPEEDUP_STEP,
//     MIN_TICKS); -> SPAWN.
//   2 hit_valid & mismatch (hit_pos>4 counts as mismatch): guess_wrong; misses+1;
//     stay UP, timer keeps running.
//   3 timer==0: guess_wrong; misses+1; -> SPAWN.
//   Hit on the same cycle as timer==0 resolves as hit (1 or 2); a wrong hit
//    at expiry counts once only and goes to SPAWN.
//  Miss reaching MAX_MISSES: guess_wrong and game_over pulse same cycle,
//   -> OVER instead of SPAWN/UP. OVER holds score and mole_position.
//  hit_valid ignored in IDLE, SPAWN, OVER. Pulse latency: event cycle +1.
//  Mid-game reset: immediate return to reset values; no pulses.
//  Widths: timer/reload 27 bits; misses 3 bits; reload subtract uses
//   compare-before-subtract (no underflow).
// STRUCTURE
//  mole_pkg: state enum {IDLE,SPAWN,UP,OVER}, slot constants SLOT_TOP..SLOT_BOT,
//   NUM_SLOTS=5, shared with vga_display position tables.
//  Sub-module lfsr16 (seed param, en, q[15:0]); BCD score inline.
// TESTING (MOLE_TICKS=10, MIN_TICKS=4, SPEEDUP_STEP=3, MAX_MISSES=3)
//  reset, no start 50 cycles -> IDLE, all pulses 0, digits 0/0, mole_position 2.
//  start, hit_pos=mole_position 3 cycles into UP -> guess_correct 1 cycle, digit_2=1,
//   new mole_position != old, next UP lasts 7 cycles.
//  start, no hits -> guess_wrong every 10 UP cycles; 3rd also game_over, playing=0.
//  score forced to 99 via hits -> further hit keeps 9/9; 09 + hit -> 1/0.
//  hit_valid with correct pos on timer==0 cycle -> guess_correct only, no miss.
//  rst low mid-UP -> outputs to reset values asynchronously; restart works.

Source files
------------

// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// mole_pkg : shared FSM states, slot encoding and slot selection helper
// Revision : 1.0
// ============================================================================
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    UP    = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [2:0] SLOT_TOP    = 3'd0;
  localparam logic [2:0] SLOT_LEFT   = 3'd1;
  localparam logic [2:0] SLOT_CENTER = 3'd2;
  localparam logic [2:0] SLOT_RIGHT  = 3'd3;
  localparam logic [2:0] SLOT_BOT    = 3'd4;

  localparam int NUM_SLOTS = 5;
  localparam int TIMER_W   = 27;
  localparam int MISS_W    = 3;

  // Fold a raw 3-bit value onto 0..4 and step past the previous slot.
  function automatic logic [2:0] pick_slot(input logic [2:0] raw, input logic [2:0] prev);
    logic [2:0] cand;
    cand = (raw >= 3'(NUM_SLOTS)) ? raw - 3'(NUM_SLOTS) : raw;
    if (cand == prev) begin
      cand = (cand == SLOT_BOT) ? SLOT_TOP : cand + 3'd1;
    end
    return cand;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mole_game_ctrl_lfsr16.sv
`default_nettype none
// ============================================================================
// lfsr16 : free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
// Revision : 1.0
// ============================================================================
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// mole_game_ctrl : whack-a-mole game FSM, mole timing, hit judging, BCD score
// Revision : 1.0
// ============================================================================
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned MOLE_TICKS   = 100_000_000,
  parameter int unsigned MIN_TICKS    = 25_000_000,
  parameter int unsigned SPEEDUP_STEP = 5_000_000,
  parameter int unsigned MAX_MISSES   = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       hit_valid_i,
  input  logic [2:0] hit_pos_i,
  output logic [2:0] mole_position_o,
  output logic       guess_correct_o,
  output logic       guess_wrong_o,
  output logic       game_over_o,
  output logic [3:0] digit_1_o,
  output logic [3:0] digit_2_o,
  output logic       playing_o
);

  localparam logic [TIMER_W-1:0] MOLE_T = TIMER_W'(MOLE_TICKS);
  localparam logic [TIMER_W-1:0] MIN_T  = TIMER_W'(MIN_TICKS);
  localparam logic [TIMER_W-1:0] STEP_T = TIMER_W'(SPEEDUP_STEP);
  localparam logic [MISS_W-1:0]  MISS_T = MISS_W'(MAX_MISSES);

  state_e             state_q,   state_d;
  logic [2:0]         mole_pos_q, mole_pos_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic [TIMER_W-1:0] reload_q,  reload_d;
  logic [MISS_W-1:0]  misses_q,  misses_d;
  logic [3:0]         tens_q,    tens_d;
  logic [3:0]         ones_q,    ones_d;
  logic               correct_q, correct_d;
  logic               wrong_q,   wrong_d;
  logic               over_q,    over_d;
  logic               playing_q, playing_d;

  logic [15:0]        lfsr_w;
  logic               lfsr_unused_w;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (1'b1),
    .q_o    (lfsr_w)
  );

  assign lfsr_unused_w = ^lfsr_w[15:3];

  always_comb begin
    state_d    = state_q;
    mole_pos_d = mole_pos_q;
    timer_d    = timer_q;
    reload_d   = reload_q;
    misses_d   = misses_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    over_d     = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        if (start_i) begin
          state_d  = SPAWN;
          misses_d = '0;
          tens_d   = 4'd0;
          ones_d   = 4'd0;
          reload_d = MOLE_T;
        end
      end

      SPAWN: begin
        mole_pos_d = pick_slot(lfsr_w[2:0], mole_pos_q);
        timer_d    = reload_q - 1'b1;
        state_d    = UP;
      end

      UP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end
        if (hit_valid_i && (hit_pos_i == mole_pos_q)) begin
          correct_d = 1'b1;
          state_d   = SPAWN;
          if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
          reload_d = (reload_q >= MIN_T + STEP_T) ? reload_q - STEP_T : MIN_T;
        end else if (hit_valid_i || (timer_q == '0)) begin
          // A wrong press on the expiry cycle is a single miss that also ends the round.
          wrong_d  = 1'b1;
          misses_d = misses_q + 1'b1;
          if (misses_d == MISS_T) begin
            over_d  = 1'b1;
            state_d = OVER;
          end else if (timer_q == '0) begin
            state_d = SPAWN;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    playing_d = (state_d == SPAWN) || (state_d == UP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mole_pos_q <= SLOT_CENTER;
      timer_q    <= '0;
      reload_q   <= MOLE_T;
      misses_q   <= '0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      over_q     <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mole_pos_q <= mole_pos_d;
      timer_q    <= timer_d;
      reload_q   <= reload_d;
      misses_q   <= misses_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      over_q     <= over_d;
      playing_q  <= playing_d;
    end
  end

  assign mole_position_o = mole_pos_q;
  assign guess_correct_o = correct_q;
  assign guess_wrong_o   = wrong_q;
  assign game_over_o     = over_q;
  assign digit_1_o       = tens_q;
  assign digit_2_o       = ones_q;
  assign playing_o       = playing_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mole_game_ctrl : model-based checks of mole_game_ctrl with directed games
// Revision : 1.0
// ============================================================================
module tb_mole_game_ctrl;

  localparam int MT = 10;
  localparam int MN = 4;
  localparam int ST = 3;
  localparam int MM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hit_valid = 1'b0;
  logic [2:0] hit_pos = 3'd0;
  logic [2:0] mole_position;
  logic       guess_correct, guess_wrong, game_over, playing;
  logic [3:0] digit_1, digit_2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mole_game_ctrl #(
    .MOLE_TICKS   (MT),
    .MIN_TICKS    (MN),
    .SPEEDUP_STEP (ST),
    .MAX_MISSES   (MM),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .hit_valid_i     (hit_valid),
    .hit_pos_i       (hit_pos),
    .mole_position_o (mole_position),
    .guess_correct_o (guess_correct),
    .guess_wrong_o   (guess_wrong),
    .game_over_o     (game_over),
    .digit_1_o       (digit_1),
    .digit_2_o       (digit_2),
    .playing_o       (playing)
  );

  always #5 clk = ~clk;

  // Game model: mode 0 idle, 1 spawn, 2 up, 3 over; m_left = UP cycles remaining incl. current
  int          m_mode, m_slot, m_left, m_score, m_miss, m_reload;
  logic [15:0] m_lfsr;
  bit          e_c, e_w, e_o;

  always @(posedge clk or negedge rst_n) begin
    int cand;
    logic [15:0] cur;
    if (!rst_n) begin
      m_mode = 0; m_slot = 2; m_left = 0; m_score = 0; m_miss = 0;
      m_reload = MT; m_lfsr = 16'hACE1; e_c = 0; e_w = 0; e_o = 0;
    end else begin
      cur = m_lfsr;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      e_c = 0; e_w = 0; e_o = 0;
      case (m_mode)
        0, 3: if (start) begin
          m_mode = 1; m_score = 0; m_miss = 0; m_reload = MT;
        end
        1: begin
          cand = int'(cur[2:0]);
          if (cand >= 5) cand -= 5;
          if (cand == m_slot) cand = (cand + 1) % 5;
          m_slot = cand; m_left = m_reload; m_mode = 2;
        end
        default: begin
          if (hit_valid && int'(hit_pos) == m_slot) begin
            e_c = 1;
            if (m_score < 99) m_score++;
            m_reload = (m_reload - ST < MN) ? MN : m_reload - ST;
            m_mode = 1;
          end else if (hit_valid || m_left == 1) begin
            e_w = 1;
            m_miss++;
            if (m_miss == MM) begin
              e_o = 1; m_mode = 3;
            end else if (m_left == 1) m_mode = 1;
            else m_left--;
          end else m_left--;
        end
      endcase
    end
  end

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("mole_position", int'(mole_position), m_slot);
      check("guess_correct", int'(guess_correct), int'(e_c));
      check("guess_wrong",   int'(guess_wrong),   int'(e_w));
      check("game_over",     int'(game_over),     int'(e_o));
      check("digit_1",       int'(digit_1),       m_score / 10);
      check("digit_2",       int'(digit_2),       m_score % 10);
      check("playing",       int'(playing),       int'(m_mode == 1 || m_mode == 2));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_up();
    int n = 0;
    while (m_mode != 2 && n < 50) begin tick(); n++; end
    check("wait_up_timeout", int'(m_mode == 2), 1);
  endtask

  task automatic wait_expiry();
    int n = 0;
    while (m_left != 1 && n < 50) begin tick(); n++; end
    check("wait_expiry_timeout", int'(m_left == 1), 1);
  endtask

  task automatic do_hit(input int pos);
    hit_valid = 1'b1; hit_pos = 3'(pos); tick(); hit_valid = 1'b0;
  endtask

  task automatic count_up(output int cnt);
    cnt = 0;
    while (!guess_wrong && cnt < 40) begin cnt++; tick(); end
  endtask

  initial begin
    int old, cnt;
    #2 chk_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle: no start for 50 cycles, stray presses ignored
    for (int i = 0; i < 50; i++) begin
      hit_valid = (i % 7 == 3); hit_pos = 3'(i % 5);
      tick();
    end
    hit_valid = 1'b0;
    check("idle_mole", int'(mole_position), 2);
    check("idle_digits", int'({digit_1, digit_2}), 0);
    check("idle_playing", int'(playing), 0);
    check("idle_pulses", int'({guess_correct, guess_wrong, game_over}), 0);

    // Correct hit 3 cycles into UP, then a shortened 7-cycle round
    pulse_start();
    wait_up();
    old = int'(mole_position);
    tick(); tick();
    do_hit(old);
    check("hit_correct", int'(guess_correct), 1);
    check("hit_digit_2", int'(digit_2), 1);
    check("hit_digit_1", int'(digit_1), 0);
    tick();
    check("new_slot_differs", int'(int'(mole_position) != old), 1);
    count_up(cnt);
    check("up_len_7", cnt, 7);
    cnt = 0;
    while (!game_over && cnt < 100) begin tick(); cnt++; end
    check("over_reached", int'(game_over), 1);
    check("over_playing", int'(playing), 0);
    check("over_wrong", int'(guess_wrong), 1);

    // Restart from OVER: three 10-cycle timeouts, third ends the game
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_up();
      count_up(cnt);
      check("up_len_10", cnt, 10);
      check("miss_game_over", int'(game_over), int'(i == 2));
    end
    check("after_over_playing", int'(playing), 0);

    // Score saturation and BCD carry
    pulse_start();
    for (int i = 1; i <= 99; i++) begin
      wait_up();
      do_hit(m_slot);
      if (i == 9)  check("score_09", int'({digit_1, digit_2}), 8'h09);
      if (i == 10) check("score_10", int'({digit_1, digit_2}), 8'h10);
    end
    check("score_99", int'({digit_1, digit_2}), 8'h99);
    wait_up();
    do_hit(m_slot);
    check("sat_correct", int'(guess_correct), 1);
    check("sat_99", int'({digit_1, digit_2}), 8'h99);

    // Correct hit on the expiry cycle: hit only
    wait_up();
    wait_expiry();
    do_hit(m_slot);
    check("expiry_hit_correct", int'(guess_correct), 1);
    check("expiry_hit_no_wrong", int'(guess_wrong), 0);

    // Wrong hit on the expiry cycle: one miss, round ends
    wait_up();
    wait_expiry();
    do_hit((m_slot + 1) % 5);
    check("expiry_wrong", int'(guess_wrong), 1);
    check("expiry_wrong_not_over", int'(game_over), 0);
    tick();
    check("expiry_wrong_once", int'(guess_wrong), 0);

    // Out-of-range press mid-round is a miss and the mole stays up
    wait_up();
    tick();
    do_hit(7);
    check("pos7_wrong", int'(guess_wrong), 1);
    check("pos7_playing", int'(playing), 1);

    // Asynchronous reset mid-UP, then restart
    wait_up();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mole", int'(mole_position), 2);
    check("rst_digits", int'({digit_1, digit_2}), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_pulses", int'({guess_correct, guess_wrong, game_over}), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_up();
    do_hit(m_slot);
    check("restart_score", int'({digit_1, digit_2}), 8'h01);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
